// File: rtl/poly_tone_synth.sv
// poly_tone_synth: polyphonic square-wave synthesiser on Avalon-MM, mixed to a 1-bit PWM output.
// Each voice has a phase-accumulator frequency, a volume and a tick-based note duration.
// Optional build macro TONE_DECAY_EN: CTRL bit1 enables per-voice volume decay.
module poly_tone_synth #(
    parameter int CHANNELS    = 4,
    parameter int ACC_W       = 24,
    parameter int VOL_W       = 4,
    parameter int DUR_W       = 16,
    parameter int TICK_DIV    = 50000,
    parameter int DECAY_TICKS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(CHANNELS)+1:0] address,
    input  logic                        write,
    input  logic [31:0]                 writedata,
    input  logic                        read,
    output logic [31:0]                 readdata,
    output logic                        irq,
    output logic                        out
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = VOL_W + $clog2(CHANNELS);
    localparam int TD_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef TONE_DECAY_EN
    localparam int DC_W  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
`endif

    logic [ACC_W-1:0]    freq   [CHANNELS];
    logic [ACC_W-1:0]    acc    [CHANNELS];
    logic [VOL_W-1:0]    vol    [CHANNELS];
    logic [DUR_W-1:0]    dur    [CHANNELS];
    logic [DUR_W-1:0]    remain [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] done_clr;
`ifdef TONE_DECAY_EN
    logic [CHANNELS-1:0] decay;
    logic [DC_W-1:0]     decay_cnt [CHANNELS];
`endif

    logic [TD_W-1:0]  tick_cnt;
    logic             tick;
    logic [CH_W-1:0]  sel_ch;
    logic [1:0]       sel_reg;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] pwm_cnt;
    logic [31:0]      rd_val;
    logic             unused_wd;

    assign sel_reg   = address[1:0];
    assign sel_ch    = CH_W'(address >> 2);
    assign tick      = (tick_cnt == TD_W'(TICK_DIV - 1));
    assign done_clr  = (write && sel_reg == 2'd3) ? writedata[16 +: CHANNELS] : '0;
    assign unused_wd = ^writedata;

    // Free-running duration prescaler, wraps at TICK_DIV-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TD_W'(1);
        end
    end

    // A voice expires on the tick that takes REMAIN from 1 to 0
    always_comb begin
        expire = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            expire[c] = tick && en[c] && (remain[c] == DUR_W'(1));
        end
    end

    // Voice state; register writes are applied last so they override tick updates in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                freq[c]   <= '0;
                acc[c]    <= '0;
                vol[c]    <= '0;
                dur[c]    <= '0;
                remain[c] <= '0;
`ifdef TONE_DECAY_EN
                decay_cnt[c] <= '0;
`endif
            end
            en   <= '0;
            done <= '0;
`ifdef TONE_DECAY_EN
            decay <= '0;
`endif
        end else begin
            // expiry set wins over a simultaneous software clear
            done <= (done & ~done_clr) | expire;
            for (int c = 0; c < CHANNELS; c++) begin
                if (en[c]) begin
                    acc[c] <= acc[c] + freq[c];
                end
                if (tick && en[c] && remain[c] != '0) begin
                    remain[c] <= remain[c] - DUR_W'(1);
                end
                if (expire[c]) begin
                    en[c] <= 1'b0;
                end
`ifdef TONE_DECAY_EN
                if (tick && en[c] && decay[c]) begin
                    if (decay_cnt[c] == '0) begin
                        decay_cnt[c] <= DC_W'(DECAY_TICKS - 1);
                        if (vol[c] != '0) begin
                            vol[c] <= vol[c] - VOL_W'(1);
                        end
                    end else begin
                        decay_cnt[c] <= decay_cnt[c] - DC_W'(1);
                    end
                end
`endif
                if (write && sel_ch == CH_W'(c)) begin
                    if (sel_reg == 2'd0) begin
                        freq[c] <= writedata[ACC_W-1:0];
                    end
                    if (sel_reg == 2'd1) begin
                        en[c]  <= writedata[0];
                        vol[c] <= writedata[VOL_W+3:4];
                        dur[c] <= writedata[DUR_W+15:16];
`ifdef TONE_DECAY_EN
                        decay[c] <= writedata[1];
`endif
                        if (writedata[0]) begin
                            acc[c]    <= '0;
                            remain[c] <= writedata[DUR_W+15:16];
`ifdef TONE_DECAY_EN
                            decay_cnt[c] <= DC_W'(DECAY_TICKS - 1);
`endif
                        end
                    end
                end
            end
        end
    end

    // Sum of audible voice contributions (square wave high and enabled)
    always_comb begin
        sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (en[c] && acc[c][ACC_W-1]) begin
                sum = sum + SUM_W'(vol[c]);
            end
        end
    end

    // PWM counter; sum is sampled once per period so the duty never changes mid-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            sum_q   <= '0;
            out     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + SUM_W'(1);
            if (pwm_cnt == '1) begin
                sum_q <= sum;
            end
            out <= (pwm_cnt < sum_q);
        end
    end

    // Register read mux
    always_comb begin
        rd_val = '0;
        case (sel_reg)
            2'd0: rd_val[ACC_W-1:0] = freq[sel_ch];
            2'd1: begin
                rd_val[0]             = en[sel_ch];
`ifdef TONE_DECAY_EN
                rd_val[1]             = decay[sel_ch];
`endif
                rd_val[VOL_W+3:4]     = vol[sel_ch];
                rd_val[DUR_W+15:16]   = dur[sel_ch];
            end
            2'd2: rd_val[DUR_W-1:0] = remain[sel_ch];
            default: begin
                rd_val[CHANNELS-1:0]       = en;
                rd_val[16+CHANNELS-1:16]   = done;
            end
        endcase
    end

    // Registered read data and level interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (read) begin
                readdata <= rd_val;
            end
            irq <= |done;
        end
    end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth with TICK_DIV=4, CHANNELS=4, DECAY_TICKS=2.
module tb_poly_tone_synth;

    logic        clk;
    logic        reset;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    wire  [31:0] readdata;
    wire         irq;
    wire         out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    poly_tone_synth #(
        .CHANNELS(4), .ACC_W(24), .VOL_W(4), .DUR_W(16), .TICK_DIV(4), .DECAY_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .irq(irq), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedges since reset release; duration ticks land on posedges where cyc becomes a multiple of 4
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic align(input int ph);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((cyc % 4) != ph && guard < 16);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (out === 1'b1) hi++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] stop_exp;
        int hi;

        reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_out", {31'b0, out}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        bus_read(4'd3, rd);  check("rst_status", rd, 32'h0);
        bus_read(4'd0, rd);  check("rst_freq0", rd, 32'h0);

        // Single sustained voice: MSB toggles every 8192 clk, 15/64 duty while high
        bus_write(4'd0, 32'h0000_0400);
        bus_write(4'd1, 32'h0000_00F1);
        repeat (8000) @(negedge clk);
        count_high(64, hi);  check("sus_low_before", hi, 0);
        repeat (300) @(negedge clk);
        count_high(64, hi);  check("sus_high_duty", hi, 15);
        repeat (8100) @(negedge clk);
        count_high(64, hi);  check("sus_low_after", hi, 0);
        bus_read(4'd0, rd);  check("sus_freq_rb", rd, 32'h0000_0400);
        bus_read(4'd1, rd);  check("sus_ctrl_rb", rd, 32'h0000_00F1);
        bus_write(4'd1, 32'h0000_00F2);
`ifdef TONE_DECAY_EN
        stop_exp = 32'h0000_00F2;
`else
        stop_exp = 32'h0000_00F0;
`endif
        bus_read(4'd1, rd);  check("stop_ctrl_bit1", rd, stop_exp);

        // Timed note on ch1, DUR=3
        align(0);
        bus_write(4'd5, 32'h0003_0081);
        bus_read(4'd6, rd);  check("timed_rem3", rd, 32'd3);
        align(0);
        bus_read(4'd6, rd);  check("timed_rem2", rd, 32'd2);
        align(0);
        bus_read(4'd6, rd);  check("timed_rem1", rd, 32'd1);
        align(0);
        bus_read(4'd6, rd);  check("timed_rem0", rd, 32'd0);
        bus_read(4'd3, rd);  check("timed_status", rd, 32'h0002_0000);
        bus_read(4'd5, rd);  check("timed_ctrl_en0", rd, 32'h0003_0080);
        check("timed_irq", {31'b0, irq}, 32'h1);
        bus_write(4'd3, 32'h0000_0000);
        bus_read(4'd3, rd);  check("clr_zero_noeffect", rd, 32'h0002_0000);
        bus_write(4'd7, 32'h0002_0000);
        @(negedge clk);
        check("clr_irq", {31'b0, irq}, 32'h0);

        // Mix: four voices, FREQ=0xFFFFFF keeps every MSB high after the first cycle
        bus_write(4'd0,  32'h00FF_FFFF);
        bus_write(4'd4,  32'h00FF_FFFF);
        bus_write(4'd8,  32'h00FF_FFFF);
        bus_write(4'd12, 32'h00FF_FFFF);
        bus_write(4'd1,  32'h0000_00F1);
        bus_write(4'd5,  32'h0000_00F1);
        bus_write(4'd9,  32'h0000_00F1);
        bus_write(4'd13, 32'h0000_00F1);
        bus_read(4'd15, rd); check("mix_status", rd, 32'h0000_000F);
        repeat (130) @(negedge clk);
        count_high(64, hi);  check("mix_duty60", hi, 60);
        bus_write(4'd13, 32'h0000_0051);
        repeat (130) @(negedge clk);
        count_high(64, hi);  check("mix_duty50", hi, 50);
        bus_write(4'd1,  32'h0);
        bus_write(4'd5,  32'h0);
        bus_write(4'd13, 32'h0);

        // Collision: CTRL write to ch2 in its expiry cycle
        align(0);
        bus_write(4'd9, 32'h0001_00F1);
        align(3);
        bus_write(4'd9, 32'h0005_00F1);
        bus_read(4'd10, rd); check("coll_remain", rd, 32'd5);
        bus_read(4'd3, rd);  check("coll_status", rd, 32'h0004_0004);
        bus_read(4'd9, rd);  check("coll_ctrl", rd, 32'h0005_00F1);
        check("coll_irq", {31'b0, irq}, 32'h1);

        // Expiry and done clear on the same cycle: set wins
        bus_write(4'd9, 32'h0);
        align(0);
        bus_write(4'd13, 32'h0001_00F1);
        align(3);
        bus_write(4'd3, 32'h0008_0000);
        bus_read(4'd3, rd);  check("setwins_status", rd, 32'h000C_0000);
        bus_read(4'd14, rd); check("setwins_remain", rd, 32'd0);

`ifdef TONE_DECAY_EN
        // Decay: VOL 4 steps down every 2 ticks and holds at 0 with EN still set
        align(0);
        bus_write(4'd1, 32'h0000_0043);
        bus_read(4'd1, rd);  check("decay_v4", rd, 32'h0000_0043);
        align(0); align(0);
        bus_read(4'd1, rd);  check("decay_v3", rd, 32'h0000_0033);
        align(0); align(0);
        bus_read(4'd1, rd);  check("decay_v2", rd, 32'h0000_0023);
        align(0); align(0);
        bus_read(4'd1, rd);  check("decay_v1", rd, 32'h0000_0013);
        align(0); align(0);
        bus_read(4'd1, rd);  check("decay_v0", rd, 32'h0000_0003);
        align(0); align(0);
        bus_read(4'd1, rd);  check("decay_hold0", rd, 32'h0000_0003);
        bus_read(4'd3, rd);  check("decay_status", rd, 32'h000C_0001);
`endif

        // Reset mid-note
        bus_write(4'd1, 32'h0000_00F1);
        repeat (130) @(negedge clk);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        bus_read(4'd1, rd);  check("pre_rst_ctrl", rd, 32'h0000_00F1);
        reset = 1'b1;
        #1;
        check("midrst_out", {31'b0, out}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(4'd0, rd);  check("midrst_freq0", rd, 32'h0);
        bus_read(4'd1, rd);  check("midrst_ctrl0", rd, 32'h0);
        bus_read(4'd10, rd); check("midrst_remain2", rd, 32'h0);
        bus_read(4'd3, rd);  check("midrst_status", rd, 32'h0);
        repeat (130) @(negedge clk);
        count_high(64, hi);  check("midrst_silent", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
